// File: rtl/jpeg_pix_sink.sv
// jpeg_pix_sink
//   Consumer end of the JPEG decoder pixel port. Each strobed pixel carries an
//   MCU-relative position. That position is turned into a raster frame-buffer
//   word address (y*width + x). Pixels that fall outside the picture are dropped.
//   Kept pixels are packed to RGB888 or RGB565 and queued in a small FIFO. The
//   FIFO drains to a ready/valid memory write port.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   width, heigth     picture size in pixels, sampled with res_avali
//   res_avali         picture size valid, starts a frame when idle
//   pic_is_411        1: 16x16 MCU, 0: 8x8 MCU, sampled with res_avali
//   x_mcu_i, y_mcu_i  MCU column/row of the current pixel
//   bo_we             pixel strobe, one pixel per asserted cycle
//   bo_r, bo_g, bo_b  pixel colour
//   bo_adr            pixel position inside the MCU
//   bi_next           sink can take a pixel in the next cycle
//   pic_end           decoder finished the last MCU
//   mem_we, mem_adr,
//   mem_dat,
//   mem_ready         memory write port; a write completes on mem_we & mem_ready
//   frame_done        one-cycle pulse after the last pixel of a frame is written
//   busy              a frame is in progress
//   wr_cnt            pixels written this frame, saturating

module jpeg_pix_sink #(
  parameter  int ADDR_W  = 24,
  parameter  int PIX_565 = 0,
  parameter  int FIFO_AW = 4,
  localparam int DAT_W   = (PIX_565 != 0) ? 16 : 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       width,
  input  logic [15:0]       heigth,
  input  logic              res_avali,
  input  logic              pic_is_411,
  input  logic [12:0]       x_mcu_i,
  input  logic [12:0]       y_mcu_i,
  input  logic              bo_we,
  input  logic [7:0]        bo_r,
  input  logic [7:0]        bo_g,
  input  logic [7:0]        bo_b,
  input  logic [7:0]        bo_adr,
  output logic              bi_next,
  input  logic              pic_end,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DAT_W-1:0]  mem_dat,
  input  logic              mem_ready,
  output logic              frame_done,
  output logic              busy,
  output logic [ADDR_W-1:0] wr_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int OW    = FIFO_AW + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;

  // picture geometry latched at frame start
  logic [15:0] w_q;
  logic [15:0] h_q;
  logic        mode411;

  // stage 1: registered pixel and its decoded MCU position
  logic        s1_vld;
  logic [23:0] s1_rgb;
  logic [3:0]  s1_row;
  logic [3:0]  s1_col;
  logic [12:0] s1_xm;
  logic [12:0] s1_ym;

  // stage 2: address computed, clipped pixels already removed
  logic              s2_vld;
  logic [ADDR_W-1:0] s2_adr;
  logic [DAT_W-1:0]  s2_dat;

  // FIFO
  logic [ADDR_W-1:0]  fifo_adr [DEPTH];
  logic [DAT_W-1:0]   fifo_dat [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   fifo_cnt;

  logic              accept;
  logic              push;
  logic              pop;
  logic              start;
  logic [16:0]       pos_x;
  logic [16:0]       pos_y;
  logic              clip;
  logic              s2_next;
  logic [ADDR_W-1:0] adr_calc;
  logic [DAT_W-1:0]  pix_packed;
  logic [OW-1:0]     occ_next;
  logic              fits;

  assign accept = bo_we & (state == RUN);
  assign start  = (state == IDLE) & res_avali;
  assign mem_we = (fifo_cnt != '0);
  assign pop    = mem_we & mem_ready;
  assign push   = s2_vld;

  // Zeroed when empty so stale FIFO contents never show on the port,
  // which also gives all-zero outputs straight out of reset.
  assign mem_adr = mem_we ? fifo_adr[rd_ptr] : '0;
  assign mem_dat = mem_we ? fifo_dat[rd_ptr] : '0;

  // Stage 2 address arithmetic; MCU size is a power of two so it is a shift.
  // The address is computed modulo 2**ADDR_W, matching truncation of the full product.
  always_comb begin
    pos_x    = (mode411 ? {s1_xm, 4'b0000} : {1'b0, s1_xm, 3'b000}) + {13'd0, s1_col};
    pos_y    = (mode411 ? {s1_ym, 4'b0000} : {1'b0, s1_ym, 3'b000}) + {13'd0, s1_row};
    clip     = (pos_x >= {1'b0, w_q}) | (pos_y >= {1'b0, h_q});
    s2_next  = s1_vld & ~clip;
    adr_calc = ADDR_W'(pos_y) * ADDR_W'(w_q) + ADDR_W'(pos_x);
    if (PIX_565 != 0) begin
      pix_packed = DAT_W'({s1_rgb[23:19], s1_rgb[15:10], s1_rgb[7:3]});
    end else begin
      pix_packed = DAT_W'(s1_rgb);
    end
  end

  // Occupancy one cycle ahead: FIFO after this cycle's push/pop plus whatever
  // sits in the two pipeline stages next cycle. Because the producer reacts one
  // cycle late to bi_next, up to two more pixels can land after the flag drops,
  // so the threshold keeps two slots free.
  always_comb begin
    occ_next = OW'(fifo_cnt) + OW'(push) + OW'(accept) + OW'(s2_next) - OW'(pop);
    fits     = (occ_next <= OW'(DEPTH - 2));
  end

  // Frame control FSM with registered bi_next, busy and frame_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      w_q        <= '0;
      h_q        <= '0;
      mode411    <= 1'b0;
      bi_next    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          bi_next <= 1'b0;
          if (res_avali) begin
            w_q     <= width;
            h_q     <= heigth;
            mode411 <= pic_is_411;
            bi_next <= fits;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (pic_end) begin
            bi_next <= 1'b0;
            state   <= DRAIN;
          end else begin
            bi_next <= fits;
          end
        end
        DRAIN: begin
          bi_next <= 1'b0;
          if (!s1_vld && !s2_vld && fifo_cnt == '0) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          bi_next <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          bi_next <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Two-stage pixel pipeline: capture and decode, then address and clip.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s1_rgb <= '0;
      s1_row <= '0;
      s1_col <= '0;
      s1_xm  <= '0;
      s1_ym  <= '0;
      s2_vld <= 1'b0;
      s2_adr <= '0;
      s2_dat <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_rgb <= {bo_r, bo_g, bo_b};
        s1_row <= mode411 ? bo_adr[7:4] : {1'b0, bo_adr[5:3]};
        s1_col <= mode411 ? bo_adr[3:0] : {1'b0, bo_adr[2:0]};
        s1_xm  <= x_mcu_i;
        s1_ym  <= y_mcu_i;
      end
      s2_vld <= s2_next;
      if (s1_vld) begin
        s2_adr <= adr_calc;
        s2_dat <= pix_packed;
      end
    end
  end

  // FIFO storage; no reset needed since the output port masks an empty FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_adr[wr_ptr] <= s2_adr;
      fifo_dat[wr_ptr] <= s2_dat;
    end
  end

  // FIFO pointers, fill count and the per-frame write counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      wr_cnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + 1'b1;
      end else if (!push && pop) begin
        fifo_cnt <= fifo_cnt - 1'b1;
      end
      if (start) begin
        wr_cnt <= '0;
      end else if (pop && wr_cnt != {ADDR_W{1'b1}}) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_pix_sink.sv
// tb_jpeg_pix_sink
//   Directed bench for jpeg_pix_sink. An RGB888 instance is checked against a
//   reference queue of expected writes. An RGB565 instance shares every input
//   and has its packed data checked from the same queue.

module tb_jpeg_pix_sink;

  localparam int ADDR_W = 24;
  localparam int DEPTH  = 16;
  localparam int LIMIT  = 5000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] width = '0;
  logic [15:0] heigth = '0;
  logic        resAvali = 1'b0;
  logic        pic411 = 1'b0;
  logic [12:0] xMcu = '0;
  logic [12:0] yMcu = '0;
  logic        boWe = 1'b0;
  logic [7:0]  boR = '0;
  logic [7:0]  boG = '0;
  logic [7:0]  boB = '0;
  logic [7:0]  boAdr = '0;
  logic        picEnd = 1'b0;
  logic        memReady = 1'b0;

  logic              biNext, memWe, frameDone, busy;
  logic [ADDR_W-1:0] memAdr, wrCnt;
  logic [23:0]       memDat;
  logic              biNext2, memWe2, frameDone2, busy2;
  logic [ADDR_W-1:0] memAdr2, wrCnt2;
  logic [15:0]       memDat2;

  int checks = 0;
  int errors = 0;

  logic [23:0] expAdr[$];
  logic [23:0] expDat[$];
  logic [15:0] exp565[$];
  logic [23:0] gotAdr[$];
  logic [23:0] gotDat[$];
  logic [15:0] got565[$];

  logic [15:0] fW = '0;
  logic [15:0] fH = '0;
  logic        f411 = 1'b0;
  logic        nextOk = 1'b0;
  logic        toggleReady = 1'b0;
  int          doneCount = 0;
  int          sentCount = 0;
  int          written = 0;
  int          maxOut = 0;
  int          stallBad = 0;
  logic        stallPrev = 1'b0;
  logic [23:0] stallAdr = '0;
  logic [23:0] stallDat = '0;
  int          doneBefore;

  always #5 clk = ~clk;

  jpeg_pix_sink #(.ADDR_W(ADDR_W), .PIX_565(0), .FIFO_AW(4)) dut (
    .clk(clk), .rst(rst), .width(width), .heigth(heigth), .res_avali(resAvali),
    .pic_is_411(pic411), .x_mcu_i(xMcu), .y_mcu_i(yMcu), .bo_we(boWe),
    .bo_r(boR), .bo_g(boG), .bo_b(boB), .bo_adr(boAdr), .bi_next(biNext),
    .pic_end(picEnd), .mem_we(memWe), .mem_adr(memAdr), .mem_dat(memDat),
    .mem_ready(memReady), .frame_done(frameDone), .busy(busy), .wr_cnt(wrCnt)
  );

  jpeg_pix_sink #(.ADDR_W(ADDR_W), .PIX_565(1), .FIFO_AW(4)) dut565 (
    .clk(clk), .rst(rst), .width(width), .heigth(heigth), .res_avali(resAvali),
    .pic_is_411(pic411), .x_mcu_i(xMcu), .y_mcu_i(yMcu), .bo_we(boWe),
    .bo_r(boR), .bo_g(boG), .bo_b(boB), .bo_adr(boAdr), .bi_next(biNext2),
    .pic_end(picEnd), .mem_we(memWe2), .mem_adr(memAdr2), .mem_dat(memDat2),
    .mem_ready(memReady), .frame_done(frameDone2), .busy(busy2), .wr_cnt(wrCnt2)
  );

  // Mid-cycle monitor: records completed writes, frame_done cycles, accepted
  // pixels, the peak number of pixels held inside the sink, and any change of
  // the write port while a write is stalled.
  always @(negedge clk) begin
    nextOk = biNext;
    if (rst) begin
      if (memWe && memReady) begin
        gotAdr.push_back(memAdr);
        gotDat.push_back(memDat);
        written++;
      end
      if (memWe2 && memReady) got565.push_back(memDat2);
      if (frameDone) doneCount++;
      if (boWe) sentCount++;
      if (stallPrev && (!memWe || memAdr != stallAdr || memDat != stallDat)) stallBad++;
      stallPrev = memWe && !memReady;
      stallAdr  = memAdr;
      stallDat  = memDat;
      if (sentCount - written > maxOut) maxOut = sentCount - written;
    end else begin
      stallPrev = 1'b0;
    end
  end

  // Optional ready toggling, changed just after the clock edge.
  always begin
    @(posedge clk);
    #1;
    if (toggleReady) memReady = ~memReady;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic startFrame(input logic [15:0] w, input logic [15:0] h, input logic m);
    fW = w;
    fH = h;
    f411 = m;
    width = w;
    heigth = h;
    pic411 = m;
    resAvali = 1'b1;
    tick(1);
    resAvali = 1'b0;
  endtask

  // Sends one pixel honouring bi_next and appends the expected write, if any.
  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                               input logic [7:0] a, input logic [12:0] xm, input logic [12:0] ym,
                               input logic last);
    int guard;
    int row, col, x, y;
    guard = 0;
    while (!nextOk && guard < LIMIT) begin
      tick(1);
      guard++;
    end
    if (guard >= LIMIT) checkOutput("send_tmo", 32'(guard), 32'(0));
    boWe = 1'b1;
    boR = r;
    boG = g;
    boB = b;
    boAdr = a;
    xMcu = xm;
    yMcu = ym;
    picEnd = last;
    row = f411 ? int'(a[7:4]) : int'(a[5:3]);
    col = f411 ? int'(a[3:0]) : int'(a[2:0]);
    x = int'(xm) * (f411 ? 16 : 8) + col;
    y = int'(ym) * (f411 ? 16 : 8) + row;
    if (x < int'(fW) && y < int'(fH)) begin
      expAdr.push_back(24'(y * int'(fW) + x));
      expDat.push_back({r, g, b});
      exp565.push_back({r[7:3], g[7:2], b[7:3]});
    end
    tick(1);
    boWe = 1'b0;
    picEnd = 1'b0;
  endtask

  task automatic waitFrameDone();
    int guard;
    guard = 0;
    while (busy && guard < LIMIT) begin
      tick(1);
      guard++;
    end
    if (guard >= LIMIT) checkOutput("done_tmo", 32'(guard), 32'(0));
    tick(3);
  endtask

  task automatic compareWrites();
    checkOutput("n_wr", 32'(gotAdr.size()), 32'(expAdr.size()));
    checkOutput("n_565", 32'(got565.size()), 32'(exp565.size()));
    for (int i = 0; i < gotAdr.size() && i < expAdr.size(); i++) begin
      checkOutput("adr", 32'(gotAdr[i]), 32'(expAdr[i]));
      checkOutput("dat", 32'(gotDat[i]), 32'(expDat[i]));
    end
    for (int i = 0; i < got565.size() && i < exp565.size(); i++) begin
      checkOutput("d565", 32'(got565[i]), 32'(exp565[i]));
    end
    checkOutput("wr_cnt", 32'(wrCnt), 32'(expAdr.size()));
  endtask

  task automatic clearQueues();
    expAdr.delete();
    expDat.delete();
    exp565.delete();
    gotAdr.delete();
    gotDat.delete();
    got565.delete();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // reset values while held in reset
    #12;
    checkOutput("rst_bi_next", 32'(biNext), 32'(0));
    checkOutput("rst_mem_we", 32'(memWe), 32'(0));
    checkOutput("rst_mem_adr", 32'(memAdr), 32'(0));
    checkOutput("rst_mem_dat", 32'(memDat), 32'(0));
    checkOutput("rst_done", 32'(frameDone), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_wr_cnt", 32'(wrCnt), 32'(0));
    tick(1);
    rst = 1'b1;
    tick(2);

    // T1: one 16x16 MCU in 411 mode, address equals bo_adr
    $display("[TB] T1 single 411 MCU");
    memReady = 1'b1;
    doneBefore = doneCount;
    startFrame(16'd16, 16'd16, 1'b1);
    checkOutput("t1_busy", 32'(busy), 32'(1));
    for (int i = 0; i < 256; i++) begin
      applyStimulus(8'(i), 8'(255 - i), 8'(i) ^ 8'h5A, 8'(i), 13'd0, 13'd0, i == 255);
    end
    waitFrameDone();
    checkOutput("t1_done", 32'(doneCount - doneBefore), 32'(1));
    checkOutput("t1_cnt", 32'(wrCnt), 32'(256));
    checkOutput("t1_last_adr", (gotAdr.size() > 255) ? 32'(gotAdr[255]) : 32'hDEAD, 32'(255));
    checkOutput("t1_busy_end", 32'(busy), 32'(0));
    compareWrites();
    clearQueues();

    // T2: 10x8 picture, two 8x8 MCUs, second one partly clipped
    $display("[TB] T2 clipping");
    doneBefore = doneCount;
    startFrame(16'd10, 16'd8, 1'b0);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 64; i++) begin
        applyStimulus(8'(i), 8'(m), 8'hA5 ^ 8'(i), 8'(i), 13'(m), 13'd0, (m == 1) && (i == 63));
      end
    end
    waitFrameDone();
    checkOutput("t2_done", 32'(doneCount - doneBefore), 32'(1));
    checkOutput("t2_cnt", 32'(wrCnt), 32'(80));
    checkOutput("t2_adr38", (gotAdr.size() > 70) ? 32'(gotAdr[70]) : 32'hDEAD, 32'(38));
    compareWrites();
    clearQueues();

    // T3: memory stalled while streaming
    $display("[TB] T3 backpressure");
    memReady = 1'b0;
    sentCount = 0;
    written = 0;
    maxOut = 0;
    stallBad = 0;
    doneBefore = doneCount;
    startFrame(16'd16, 16'd16, 1'b1);
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          applyStimulus(8'(3 * i), 8'(i + 7), 8'(i), 8'(i), 13'd0, 13'd0, i == 63);
        end
      end
      begin
        tick(38);
        checkOutput("t3_bi_next", 32'(biNext), 32'(0));
        checkOutput("t3_we_stall", 32'(memWe), 32'(1));
        checkOutput("t3_held", 32'(sentCount - written), 32'(DEPTH));
        tick(2);
        memReady = 1'b1;
      end
    join
    waitFrameDone();
    checkOutput("t3_done", 32'(doneCount - doneBefore), 32'(1));
    checkOutput("t3_maxout", 32'(maxOut), 32'(DEPTH));
    checkOutput("t3_stable", 32'(stallBad), 32'(0));
    compareWrites();
    clearQueues();

    // T5: reset in the middle of a frame with pixels buffered
    $display("[TB] T5 mid-frame reset");
    memReady = 1'b0;
    startFrame(16'd16, 16'd16, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'(i), 8'(i), 8'(i), 8'(i), 13'd0, 13'd0, 1'b0);
    end
    tick(3);
    checkOutput("t5_buffered", 32'(memWe), 32'(1));
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t5_bi_next", 32'(biNext), 32'(0));
    checkOutput("t5_mem_we", 32'(memWe), 32'(0));
    checkOutput("t5_mem_adr", 32'(memAdr), 32'(0));
    checkOutput("t5_mem_dat", 32'(memDat), 32'(0));
    checkOutput("t5_busy", 32'(busy), 32'(0));
    checkOutput("t5_wr_cnt", 32'(wrCnt), 32'(0));
    tick(2);
    rst = 1'b1;
    memReady = 1'b1;
    tick(20);
    checkOutput("t5_no_write", 32'(gotAdr.size()), 32'(0));
    checkOutput("t5_idle", 32'(busy), 32'(0));
    clearQueues();

    // T4: single pixel in RGB565, pic_end together with the pixel
    $display("[TB] T4 RGB565 packing");
    doneBefore = doneCount;
    startFrame(16'd8, 16'd8, 1'b0);
    applyStimulus(8'hFF, 8'h80, 8'h01, 8'd0, 13'd0, 13'd0, 1'b1);
    waitFrameDone();
    checkOutput("t4_565", (got565.size() > 0) ? 32'(got565[0]) : 32'hDEAD, 32'h0000FC00);
    checkOutput("t4_888", (gotDat.size() > 0) ? 32'(gotDat[0]) : 32'hDEAD, 32'h00FF8001);
    checkOutput("t4_done", 32'(doneCount - doneBefore), 32'(1));
    compareWrites();
    clearQueues();

    // T6: pic_end with the final pixel while mem_ready toggles
    $display("[TB] T6 end with toggling ready");
    doneBefore = doneCount;
    toggleReady = 1'b1;
    startFrame(16'd8, 16'd8, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'(i), 8'(2 * i), 8'(i + 1), 8'(63 - 4 * i), 13'd0, 13'd0, i == 15);
    end
    waitFrameDone();
    toggleReady = 1'b0;
    memReady = 1'b1;
    tick(4);
    checkOutput("t6_done", 32'(doneCount - doneBefore), 32'(1));
    checkOutput("t6_busy", 32'(busy), 32'(0));
    checkOutput("t6_last_adr", (gotAdr.size() > 15) ? 32'(gotAdr[15]) : 32'hDEAD, 32'(3));
    compareWrites();
    clearQueues();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
